// File: rtl/alu_pipe.sv
// alu_pipe: two-stage registered ALU with valid/ready handshake, tag passthrough
// and a count of delivered results. Rev 1.0.
`default_nettype none

module alu_pipe #(
   parameter int NUMBITS = 8,
   parameter int TAGBITS = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NUMBITS-1:0] A,
   input  logic [NUMBITS-1:0] B,
   input  logic [2:0]         opcode,
   input  logic [TAGBITS-1:0] in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUMBITS-1:0] result,
   output logic               carryout,
   output logic               overflow,
   output logic               zero,
   output logic [TAGBITS-1:0] out_tag,
   output logic [15:0]        done_count
);

   logic               r_rst_done;
   logic               r_s1_valid;
   logic [NUMBITS-1:0] r_s1_a;
   logic [NUMBITS-1:0] r_s1_b;
   logic [2:0]         r_s1_op;
   logic [TAGBITS-1:0] r_s1_tag;
   logic               r_s2_valid;
   logic [NUMBITS-1:0] r_s2_res;
   logic               r_s2_c;
   logic               r_s2_o;
   logic               r_s2_z;
   logic [TAGBITS-1:0] r_s2_tag;
   logic [15:0]        r_done;

   logic               w_s2_adv;
   logic               w_s1_adv;
   logic               w_accept;
   logic [NUMBITS:0]   w_sum;
   logic [NUMBITS:0]   w_diff;
   logic [NUMBITS-1:0] w_res;
   logic               w_c;
   logic               w_o;
   logic               w_z;
   logic               w_sa;
   logic               w_sb;
   logic               w_sr;

   // Intake stays closed until the first edge after reset is released,
   // so a release near a clock edge cannot admit a half-reset operation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_rst_done <= 1'b0;
      else        r_rst_done <= 1'b1;
   end

   assign w_s2_adv = !r_s2_valid || out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;
   assign in_ready = w_s1_adv && r_rst_done;
   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
      w_diff = {1'b0, r_s1_a} - {1'b0, r_s1_b};
      w_res  = '0;
      w_c    = 1'b0;
      w_o    = 1'b0;
      w_sa   = r_s1_a[NUMBITS-1];
      w_sb   = r_s1_b[NUMBITS-1];
      case (r_s1_op)
         3'b000: begin
            w_res = w_sum[NUMBITS-1:0];
            w_c   = w_sum[NUMBITS];
         end
         3'b001: begin
            w_res = w_diff[NUMBITS-1:0];
            w_c   = w_diff[NUMBITS];
         end
         3'b010: begin
            w_res = w_sum[NUMBITS-1:0];
            w_o   = (w_sa == w_sb) && (w_sum[NUMBITS-1] != w_sa);
         end
         3'b011: begin
            w_res = w_diff[NUMBITS-1:0];
            w_o   = (w_sa != w_sb) && (w_diff[NUMBITS-1] != w_sa);
         end
         3'b100:  w_res = r_s1_a & r_s1_b;
         3'b101:  w_res = r_s1_a | r_s1_b;
         3'b110:  w_res = r_s1_a ^ r_s1_b;
         default: w_res = {1'b0, r_s1_a[NUMBITS-1:1]};
      endcase
      w_sr = w_res[NUMBITS-1];
      w_z  = (w_res == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_op    <= '0;
         r_s1_tag   <= '0;
         r_s2_valid <= 1'b0;
         r_s2_res   <= '0;
         r_s2_c     <= 1'b0;
         r_s2_o     <= 1'b0;
         r_s2_z     <= 1'b0;
         r_s2_tag   <= '0;
         r_done     <= '0;
      end else begin
         if (w_s1_adv) begin
            r_s1_valid <= w_accept;
            r_s1_a     <= A;
            r_s1_b     <= B;
            r_s1_op    <= opcode;
            r_s1_tag   <= in_tag;
         end
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_res   <= w_res;
            r_s2_c     <= w_c;
            r_s2_o     <= w_o;
            r_s2_z     <= w_z;
            r_s2_tag   <= r_s1_tag;
         end
         if (r_s2_valid && out_ready) r_done <= r_done + 16'd1;
      end
   end

   assign out_valid  = r_s2_valid;
   assign result     = r_s2_res;
   assign carryout   = r_s2_c;
   assign overflow   = r_s2_o;
   assign zero       = r_s2_z;
   assign out_tag    = r_s2_tag;
   assign done_count = r_done;

   // Result sign is only consumed by the flag terms above through w_sum/w_diff.
   logic w_unused;
   assign w_unused = w_sr;

endmodule

`default_nettype wire
